clk_duty_ctrl: RTL and testbench
================================

CLK_DUTY_CTRL -- requirements
Module: clk_duty_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, width of the period/high-time count fields.
REQ-002 Parameter DEF_PERIOD, default 10, reset period in clk cycles.
REQ-003 Parameter DEF_HIGH, default 4, reset high time in clk cycles (40% duty).
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  level; 1 = generate clk_out, 0 = stop at the next period boundary.
REQ-007 cfg_valid  input  1  new period/high pair presented.
REQ-008 cfg_ready  output  1  controller can accept a config this cycle.
REQ-009 cfg_period  input  CNT_W  requested period in cycles.
REQ-010 cfg_high  input  CNT_W  requested high time in cycles.
REQ-011 clk_out  output  1  registered generated clock, low phase first, then high phase.
REQ-012 period_start  output  1  one-cycle pulse in the first cycle of every generated period.
REQ-013 busy  output  1  high in RUN and DRAIN.
REQ-014 cfg_err  output  1  one-cycle pulse when an accepted config is rejected as invalid.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-016 Active registers per/hi and a CNT_W counter c SHALL define the waveform: in RUN/DRAIN, clk_out = 1 iff c >= per-hi, so each period is per-hi low cycles followed by hi high cycles.
REQ-017 IDLE->RUN SHALL occur on the first edge with en=1; the first RUN cycle has c=0, clk_out=0 and period_start=1.
REQ-018 In RUN/DRAIN, c SHALL increment each cycle and wrap from per-1 to 0; period_start SHALL be 1 exactly when c=0.
REQ-019 RUN->DRAIN SHALL occur when en=0; DRAIN->RUN SHALL occur when en=1, with no gap and no counter reset.
REQ-020 DRAIN SHALL finish the current period; on the wrap edge it SHALL go to IDLE with c=0 and clk_out=0, and no truncated high phase is allowed.
REQ-021 In IDLE, clk_out=0, period_start=0 and busy=0.
REQ-022 A config SHALL be accepted on an edge with cfg_valid and cfg_ready both high, and latched into a shadow register; a pending flag is then set.
REQ-023 cfg_ready SHALL equal NOT pending.
REQ-024 A config SHALL be valid iff cfg_period >= 2 and 1 <= cfg_high <= cfg_period-1.
REQ-025 An invalid config SHALL still complete the handshake, SHALL pulse cfg_err the next cycle, SHALL leave per/hi unchanged, and SHALL NOT set pending.
REQ-026 A pending shadow SHALL load per/hi on the wrap edge (c=per-1) in RUN/DRAIN, or on the next edge in IDLE, and SHALL clear pending on the same edge.
REQ-027 If a config is accepted on the same edge as a wrap, it SHALL apply at the following wrap; the period just starting uses the old values.
REQ-028 Comparisons SHALL be unsigned CNT_W-bit; per up to 2^CNT_W-1 SHALL be supported without overflow of c.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, c=0, per=DEF_PERIOD, hi=DEF_HIGH, pending=0, clk_out=0, period_start=0, busy=0, cfg_err=0 and cfg_ready=1.
REQ-030 Reset mid-period SHALL discard the shadow and truncate the period; operation resumes per REQ-017 after release if en=1.

Structure
REQ-031 The package clk_duty_pkg SHALL hold the state enum (IDLE/RUN/DRAIN) and the default period/high constants.
REQ-032 The block SHALL contain one sub-module, duty_counter (counter c with wrap and terminal-count flag); the FSM, shadow and handshake stay in clk_duty_ctrl.

Verification
REQ-033 Reset, en=1 held -> clk_out repeats 6 low/4 high, period_start every 10 cycles, busy=1.
REQ-034 cfg 5/1 accepted at c=3 -> current 10-cycle period completes, then 4 low/1 high repeating; cfg_ready is low from acceptance until the wrap.
REQ-035 cfg 8/0, then 3/3 -> cfg_err pulses twice, waveform stays 6/4, cfg_ready stays 1.
REQ-036 en=0 at c=3 -> period completes (high c=6..9), IDLE after the wrap, busy=0, clk_out=0; en=1 at c=8 of a DRAIN period -> seamless continuation.
REQ-037 rst asserted during the high phase with a pending cfg 20/5 -> clk_out=0 asynchronously; after release the waveform is 6/4 (shadow discarded).
REQ-038 cfg_valid held with a new value while pending -> no second acceptance until the wrap, then accepted the cycle after.

Source files
------------

// File: rtl/clk_duty_pkg.sv
// clk_duty_pkg: shared state encoding and reset waveform defaults for clk_duty_ctrl
package clk_duty_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int DEF_PERIOD_C = 10;
  localparam int DEF_HIGH_C = 4;
endpackage

// File: rtl/duty_counter.sv
// duty_counter: period counter c that wraps at per-1, with terminal-count flag and next value
module duty_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] per,
  output logic [CNT_W-1:0] c_nxt,
  output logic             tc
);
  logic [CNT_W-1:0] c;
  assign tc = run && c == per - 1'b1;
  assign c_nxt = (tc || !run) ? '0 : c + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) c <= '0;
    else c <= c_nxt;
endmodule

// File: rtl/clk_duty_ctrl.sv
// clk_duty_ctrl: programmable low-then-high clock generator with shadowed config applied at period boundaries
module clk_duty_ctrl import clk_duty_pkg::*; #(
  parameter int CNT_W = 8,
  parameter int DEF_PERIOD = DEF_PERIOD_C,
  parameter int DEF_HIGH = DEF_HIGH_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             clk_out,
  output logic             period_start,
  output logic             busy,
  output logic             cfg_err
);
  state_t st, st_n;
  logic [CNT_W-1:0] per, hi, sp, sh, c_nxt, per_n, hi_n;
  logic pend, tc, acc, ok, ld, nb;
  duty_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .run(st != IDLE), .per(per), .c_nxt(c_nxt), .tc(tc)
  );
  assign cfg_ready = !pend;
  assign acc = cfg_valid && !pend;
  assign ok = cfg_high != '0 && cfg_high < cfg_period;
  assign ld = pend && (st == IDLE || tc);
  assign per_n = ld ? sp : per;
  assign hi_n = ld ? sh : hi;
  // Stopping is only possible at a period boundary, so no high phase is ever cut short
  assign st_n = en ? RUN : (st == IDLE || tc) ? IDLE : DRAIN;
  assign nb = st_n != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      per <= CNT_W'(DEF_PERIOD);
      hi <= CNT_W'(DEF_HIGH);
      sp <= '0;
      sh <= '0;
      pend <= 1'b0;
      clk_out <= 1'b0;
      period_start <= 1'b0;
      busy <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      st <= st_n;
      per <= per_n;
      hi <= hi_n;
      if (acc && ok) begin
        sp <= cfg_period;
        sh <= cfg_high;
      end
      pend <= (acc && ok) || (pend && !ld);
      clk_out <= nb && c_nxt >= per_n - hi_n;
      period_start <= nb && c_nxt == '0;
      busy <= nb;
      cfg_err <= acc && !ok;
    end
endmodule

// File: tb/tb_clk_duty_ctrl.sv
// tb_clk_duty_ctrl: randomized and directed checks of clk_duty_ctrl against a cycle-level waveform model
module tb_clk_duty_ctrl;
  logic clk = 1'b0, rst, en, cfg_valid, cfg_ready, clk_out, period_start, busy, cfg_err;
  logic [7:0] cfg_period, cfg_high;
  int checks = 0, fails = 0;
  int mper, mhi, msp, msh, mk;
  bit mact, mpend, merr;

  clk_duty_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .clk_out(clk_out),
    .period_start(period_start), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mact = 0; mk = 0; mper = 10; mhi = 4; msp = 0; msh = 0; mpend = 0; merr = 0;
  endtask

  // One generated period is mk = 0 .. mper-1; the generator may only stop or retune at its end
  task automatic model_step();
    bit at_end, bnd, acc, ok;
    at_end = mact && mk == mper - 1;
    bnd = !mact || at_end;
    acc = cfg_valid && !mpend;
    ok = int'(cfg_high) >= 1 && int'(cfg_high) <= int'(cfg_period) - 1;
    merr = acc && !ok;
    if (mpend && bnd) begin mper = msp; mhi = msh; mpend = 0; end
    if (acc && ok) begin msp = int'(cfg_period); msh = int'(cfg_high); mpend = 1; end
    mk = bnd ? 0 : mk + 1;
    mact = en || (mact && !at_end);
  endtask

  function automatic logic [4:0] exp_vec();
    return {mact && mk >= mper - mhi, mact && mk == 0, mact, !mpend, merr};
  endfunction

  function automatic logic [4:0] dut_vec();
    return {clk_out, period_start, busy, cfg_ready, cfg_err};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cfg(input bit v, input int p, input int h);
    cfg_valid = v; cfg_period = 8'(p); cfg_high = 8'(h);
  endtask

  task automatic test_reset();
    checks++;
    if (dut_vec() !== 5'b00010) begin fails++; $display("FAIL reset_state got %b want 00010", dut_vec()); end
    rst = 0;
    tick();
    checks++;
    if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL reset_idle got %b want %b", dut_vec(), exp_vec()); end
  endtask

  task automatic test_default();
    int hc = 0, pc = 0;
    en = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      hc += int'(clk_out); pc += int'(period_start);
      checks++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL default cyc %0d got %b want %b", i, dut_vec(), exp_vec()); end
    end
    checks++;
    if (hc != 16 || pc != 4) begin fails++; $display("FAIL default_shape high %0d starts %0d want 16 4", hc, pc); end
  endtask

  task automatic test_cfg_apply();
    for (int i = 0; i < 20 && mk != 3; i++) tick();
    checks++;
    if (mk != 3) begin fails++; $display("FAIL cfg_apply_sync c=%0d want 3", mk); end
    set_cfg(1, 5, 1);
    tick();
    set_cfg(0, 0, 0);
    checks++;
    if (cfg_ready !== 1'b0) begin fails++; $display("FAIL cfg_apply_ready got %b want 0", cfg_ready); end
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL cfg_apply cyc %0d got %b want %b", i, dut_vec(), exp_vec()); end
    end
    checks++;
    if (mper != 5 || mhi != 1) begin fails++; $display("FAIL cfg_apply_model per %0d hi %0d want 5 1", mper, mhi); end
    set_cfg(1, 10, 4);
    tick();
    set_cfg(0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL cfg_restore cyc %0d got %b want %b", i, dut_vec(), exp_vec()); end
    end
  endtask

  task automatic test_invalid();
    int ec = 0, rc = 0;
    set_cfg(1, 8, 0);
    tick();
    ec += int'(cfg_err); rc += int'(!cfg_ready);
    set_cfg(1, 3, 3);
    tick();
    ec += int'(cfg_err); rc += int'(!cfg_ready);
    set_cfg(0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      ec += int'(cfg_err); rc += int'(!cfg_ready);
      checks++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL invalid cyc %0d got %b want %b", i, dut_vec(), exp_vec()); end
    end
    checks++;
    if (ec != 2 || rc != 0) begin fails++; $display("FAIL invalid_count errs %0d notready %0d want 2 0", ec, rc); end
  endtask

  task automatic test_drain();
    int bz = 0;
    for (int i = 0; i < 20 && mk != 3; i++) tick();
    en = 0;
    for (int i = 0; i < 20 && mact; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL drain cyc %0d got %b want %b", i, dut_vec(), exp_vec()); end
    end
    checks++;
    if (busy !== 1'b0 || clk_out !== 1'b0 || mact) begin fails++; $display("FAIL drain_idle busy %b clk_out %b want 0 0", busy, clk_out); end
    en = 1;
    for (int i = 0; i < 20 && mk != 2; i++) tick();
    en = 0;
    for (int i = 0; i < 20 && mk != 8; i++) tick();
    en = 1;
    for (int i = 0; i < 25; i++) begin
      tick();
      bz += int'(!busy);
      checks++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL resume cyc %0d got %b want %b", i, dut_vec(), exp_vec()); end
    end
    checks++;
    if (bz != 0) begin fails++; $display("FAIL resume_gap idle cycles %0d want 0", bz); end
  endtask

  task automatic test_reset_pending();
    for (int i = 0; i < 20 && mk != 5; i++) tick();
    set_cfg(1, 20, 5);
    tick();
    set_cfg(0, 0, 0);
    checks++;
    if (clk_out !== 1'b1 || cfg_ready !== 1'b0) begin fails++; $display("FAIL rstpend_pre clk_out %b ready %b want 1 0", clk_out, cfg_ready); end
    #2 rst = 1;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== 5'b00010) begin fails++; $display("FAIL rstpend_async got %b want 00010", dut_vec()); end
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL rstpend cyc %0d got %b want %b", i, dut_vec(), exp_vec()); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20 && mk != 2; i++) tick();
    set_cfg(1, 5, 2);
    tick();
    set_cfg(1, 7, 3);
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL b2b cyc %0d got %b want %b", i, dut_vec(), exp_vec()); end
      if (!cfg_ready && msp == 7) set_cfg(0, 0, 0);
    end
    set_cfg(0, 0, 0);
    checks++;
    if (mper != 7 || mhi != 3) begin fails++; $display("FAIL b2b_model per %0d hi %0d want 7 3", mper, mhi); end
  endtask

  task automatic test_random();
    int p;
    for (int i = 0; i < 1500; i++) begin
      en = $urandom_range(0, 15) != 0;
      p = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 20));
      set_cfg($urandom_range(0, 9) == 0, p, int'($urandom_range(0, p + 1)));
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL random cyc %0d got %b want %b per %0d hi %0d", i, dut_vec(), exp_vec(), mper, mhi); end
    end
    set_cfg(0, 0, 0);
  endtask

  task automatic test_max();
    en = 1;
    set_cfg(1, 255, 254);
    tick();
    set_cfg(0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL max cyc %0d got %b want %b", i, dut_vec(), exp_vec()); end
    end
  endtask

  initial begin
    rst = 1; en = 0; set_cfg(0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_default();
    test_cfg_apply();
    test_invalid();
    test_drain();
    test_reset_pending();
    test_back_to_back();
    test_random();
    test_max();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
